snake_game_ctrl: RTL and testbench

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: start/play/eat/over control, frame-paced move ticks,
// BCD score, saturating length and LFSR-driven apple placement.
module snake_game_ctrl #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int START_LEN = 3,
  parameter int MAX_LEN   = 32,
  parameter int SPEED_DIV = 4,
  parameter int APPLE_X0  = 25,
  parameter int APPLE_Y0  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [1:0] coll_state_i,
  output logic       move_tick_o,
  output logic       grow_o,
  output logic [5:0] apple_x_o,
  output logic [4:0] apple_y_o,
  output logic [7:0] score_o,
  output logic [5:0] length_o,
  output logic       playing_o,
  output logic       game_over_o
);

  localparam int CNT_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_EAT, S_OVER} state_t;

  state_t           state_q, state_d;
  logic             start_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             apple_f_q, apple_f_d, death_f_q, death_f_d;
  logic             move_q, move_d, grow_q, grow_d;
  logic [5:0]       ax_q, ax_d, len_q, len_d;
  logic [4:0]       ay_q, ay_d;
  logic [7:0]       score_q, score_d;
  logic             playing_q, playing_d, over_q, over_d;

  logic       start_edge, apple_now, death_now;
  logic [5:0] rx_raw, rx_wrap, rx, len_inc;
  logic [4:0] ry_raw, ry_wrap, ry;
  logic [7:0] score_inc;

  assign start_edge = start_btn & ~start_q;
  assign apple_now  = (coll_state_i == 2'b01);
  assign death_now  = coll_state_i[1];

  // Fold the raw LFSR field into the grid, then pull border hits one cell inward.
  always_comb begin
    rx_raw  = lfsr_q[5:0];
    rx_wrap = (rx_raw >= 6'(GRID_W)) ? rx_raw - 6'(GRID_W) : rx_raw;
    if (rx_wrap == 6'd0)               rx = 6'd1;
    else if (rx_wrap == 6'(GRID_W-1))  rx = 6'(GRID_W-2);
    else                               rx = rx_wrap;
    ry_raw  = lfsr_q[10:6];
    ry_wrap = (ry_raw >= 5'(GRID_H)) ? ry_raw - 5'(GRID_H) : ry_raw;
    if (ry_wrap == 5'd0)               ry = 5'd1;
    else if (ry_wrap == 5'(GRID_H-1))  ry = 5'(GRID_H-2);
    else                               ry = ry_wrap;
  end

  always_comb begin
    if (score_q == 8'h99)          score_inc = 8'h99;
    else if (score_q[3:0] == 4'd9) score_inc = {score_q[7:4] + 4'd1, 4'd0};
    else                           score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    len_inc = (len_q >= 6'(MAX_LEN)) ? len_q : len_q + 6'd1;
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d     = cnt_q;
    apple_f_d = apple_f_q;
    death_f_d = death_f_q;
    move_d    = 1'b0;
    grow_d    = 1'b0;
    ax_d      = ax_q;
    ay_d      = ay_q;
    score_d   = score_q;
    len_d     = len_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d   = S_PLAY;
          score_d   = 8'h00;
          len_d     = 6'(START_LEN);
          ax_d      = 6'(APPLE_X0);
          ay_d      = 5'(APPLE_Y0);
          cnt_d     = '0;
          apple_f_d = 1'b0;
          death_f_d = 1'b0;
        end
      end
      S_PLAY, S_EAT: begin
        if (state_q == S_EAT) begin
          score_d = score_inc;
          len_d   = len_inc;
          ax_d    = rx;
          ay_d    = ry;
        end
        state_d = S_PLAY;
        if (frame_tick) begin
          apple_f_d = 1'b0;
          death_f_d = 1'b0;
          // Death wins over an apple seen in the same frame.
          if (death_f_q | death_now) begin
            state_d = S_OVER;
          end else begin
            if (cnt_q == CNT_W'(SPEED_DIV-1)) begin
              cnt_d  = '0;
              move_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (apple_f_q | apple_now) begin
              state_d = S_EAT;
              grow_d  = 1'b1;
            end
          end
        end else begin
          apple_f_d = apple_f_q | apple_now;
          death_f_d = death_f_q | death_now;
        end
      end
      default: state_d = S_IDLE;
    endcase
    playing_d = (state_d == S_PLAY) || (state_d == S_EAT);
    over_d    = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      lfsr_q    <= 16'hACE1;
      cnt_q     <= '0;
      apple_f_q <= 1'b0;
      death_f_q <= 1'b0;
      move_q    <= 1'b0;
      grow_q    <= 1'b0;
      ax_q      <= 6'(APPLE_X0);
      ay_q      <= 5'(APPLE_Y0);
      score_q   <= 8'h00;
      len_q     <= 6'(START_LEN);
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_btn;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      apple_f_q <= apple_f_d;
      death_f_q <= death_f_d;
      move_q    <= move_d;
      grow_q    <= grow_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      score_q   <= score_d;
      len_q     <= len_d;
      playing_q <= playing_d;
      over_q    <= over_d;
    end
  end

  assign move_tick_o = move_q;
  assign grow_o      = grow_q;
  assign apple_x_o   = ax_q;
  assign apple_y_o   = ay_q;
  assign score_o     = score_q;
  assign length_o    = len_q;
  assign playing_o   = playing_q;
  assign game_over_o = over_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomised bench for snake_game_ctrl against a frame-level behavioural model,
// plus literal checks of the key game scenarios.
module tb_snake_game_ctrl;

  localparam int GRID_W = 40, GRID_H = 30, START_LEN = 3, MAX_LEN = 32, SPEED_DIV = 4;
  localparam int AX0 = 25, AY0 = 15;
  localparam int M_IDLE = 0, M_PLAY = 1, M_EAT = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, start_btn = 1'b0;
  logic [1:0] coll_state_i = 2'b00;
  logic       move_tick_o, grow_o, playing_o, game_over_o;
  logic [5:0] apple_x_o, length_o;
  logic [4:0] apple_y_o;
  logic [7:0] score_o;

  int n_pass = 0, n_total = 0;
  int n_move = 0, n_grow = 0;

  // model state
  int m_mode = M_IDLE, m_score = 0, m_len = START_LEN, m_ax = AX0, m_ay = AY0;
  int m_frames = 0, m_lfsr = 16'hACE1, m_cur_lfsr = 0;
  bit m_af = 0, m_df = 0, m_move = 0, m_grow = 0, m_start_prev = 0;
  bit m_edge = 0, m_anow = 0, m_dnow = 0;

  snake_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .coll_state_i(coll_state_i), .move_tick_o(move_tick_o), .grow_o(grow_o),
    .apple_x_o(apple_x_o), .apple_y_o(apple_y_o), .score_o(score_o),
    .length_o(length_o), .playing_o(playing_o), .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic int next_lfsr(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 16'hFFFF) | fb;
  endfunction

  function automatic int relocate(input int v, input int n);
    int r;
    r = v % n;
    if (r == 0) r = 1;
    else if (r == n - 1) r = n - 2;
    return r;
  endfunction

  function automatic int to_bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_score = 0; m_len = START_LEN; m_ax = AX0; m_ay = AY0;
      m_frames = 0; m_lfsr = 16'hACE1; m_af = 0; m_df = 0; m_move = 0; m_grow = 0;
      m_start_prev = 0;
    end else begin
      m_edge = start_btn && !m_start_prev;
      m_start_prev = start_btn;
      m_cur_lfsr = m_lfsr;
      m_lfsr = next_lfsr(m_lfsr);
      m_move = 0;
      m_grow = 0;
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if (m_edge) begin
          m_mode = M_PLAY; m_score = 0; m_len = START_LEN; m_ax = AX0; m_ay = AY0;
          m_frames = 0; m_af = 0; m_df = 0;
        end
      end else begin
        if (m_mode == M_EAT) begin
          if (m_score < 99) m_score++;
          if (m_len < MAX_LEN) m_len++;
          m_ax = relocate(m_cur_lfsr & 63, GRID_W);
          m_ay = relocate((m_cur_lfsr >> 6) & 31, GRID_H);
        end
        m_anow = (coll_state_i == 2'b01);
        m_dnow = coll_state_i[1];
        m_mode = M_PLAY;
        if (frame_tick) begin
          if (m_df || m_dnow) m_mode = M_OVER;
          else begin
            m_frames++;
            if (m_frames % SPEED_DIV == 0) m_move = 1;
            if (m_af || m_anow) begin m_mode = M_EAT; m_grow = 1; end
          end
          m_af = 0; m_df = 0;
        end else begin
          m_af = m_af | m_anow;
          m_df = m_df | m_dnow;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("move_tick", move_tick_o, m_move);
    chk("grow", grow_o, m_grow);
    chk("score", score_o, to_bcd(m_score));
    chk("length", length_o, m_len);
    chk("apple_x", apple_x_o, m_ax);
    chk("apple_y", apple_y_o, m_ay);
    chk("playing", playing_o, (m_mode == M_PLAY || m_mode == M_EAT));
    chk("game_over", game_over_o, (m_mode == M_OVER));
    chk("apple_in_field", (apple_x_o >= 1 && apple_x_o <= GRID_W-2 &&
                           apple_y_o >= 1 && apple_y_o <= GRID_H-2), 1);
  end

  task automatic cyc(input bit ft, input bit st, input logic [1:0] c);
    frame_tick = ft; start_btn = st; coll_state_i = c;
    @(posedge clk); #1;
    if (move_tick_o) n_move++;
    if (grow_o) n_grow++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"}, score_o, 8'h00);
    chk({tag, "_len"}, length_o, START_LEN);
    chk({tag, "_ax"}, apple_x_o, AX0);
    chk({tag, "_ay"}, apple_y_o, AY0);
    chk({tag, "_play"}, playing_o, 0);
    chk({tag, "_over"}, game_over_o, 0);
    chk({tag, "_move"}, move_tick_o, 0);
    chk({tag, "_grow"}, grow_o, 0);
  endtask

  initial begin
    bit ft, st;
    logic [1:0] c;
    int r;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;
    cyc(0, 0, 2'b00);
    cyc(0, 1, 2'b00);

    // eight quiet frames: two move pulses
    n_move = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b00); cyc(0, 1, 2'b00); cyc(1, 1, 2'b00);
    end
    cyc(0, 1, 2'b00); cyc(0, 1, 2'b00);
    chk("quiet_playing", playing_o, 1);
    chk("quiet_moves", n_move, 2);
    chk("quiet_score", score_o, 8'h00);
    chk("quiet_len", length_o, 3);

    // apple held five cycles in one frame: one eat
    n_grow = 0;
    repeat (5) cyc(0, 1, 2'b01);
    cyc(1, 1, 2'b00); cyc(0, 1, 2'b00); cyc(0, 1, 2'b00);
    chk("eat_grow", n_grow, 1);
    chk("eat_score", score_o, 8'h01);
    chk("eat_len", length_o, 4);
    chk("eat_apple_ok", (apple_x_o >= 1 && apple_x_o <= 38 && apple_y_o >= 1 && apple_y_o <= 28), 1);

    // apple and border in one frame: death
    n_grow = 0;
    cyc(0, 1, 2'b01); cyc(0, 1, 2'b10); cyc(1, 1, 2'b00); cyc(0, 1, 2'b00);
    chk("death_over", game_over_o, 1);
    chk("death_score", score_o, 8'h01);
    chk("death_len", length_o, 4);
    chk("death_grow", n_grow, 0);

    // restart, then die with start held: no second restart
    cyc(0, 0, 2'b00); cyc(0, 1, 2'b00);
    chk("restart_score", score_o, 8'h00);
    chk("restart_len", length_o, 3);
    chk("restart_ax", apple_x_o, 25);
    chk("restart_ay", apple_y_o, 15);
    chk("restart_play", playing_o, 1);
    cyc(0, 1, 2'b11); cyc(1, 1, 2'b00);
    repeat (4) cyc(0, 1, 2'b00);
    chk("held_start_over", game_over_o, 1);

    // score carry and saturation
    cyc(0, 0, 2'b00); cyc(0, 1, 2'b00);
    for (int i = 0; i < 110; i++) begin
      cyc(0, 1, 2'b01); cyc(1, 1, 2'b00); cyc(0, 1, 2'b00);
      if (i == 8) chk("score_09", score_o, 8'h09);
      if (i == 9) chk("score_10", score_o, 8'h10);
    end
    chk("score_sat", score_o, 8'h99);
    chk("len_sat", length_o, 32);

    // reset mid-frame with apple pending
    cyc(0, 1, 2'b01); cyc(0, 1, 2'b01);
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    n_grow = 0;
    cyc(1, 0, 2'b01); cyc(0, 0, 2'b00);
    reset = 1'b1;
    cyc(1, 0, 2'b00); cyc(0, 0, 2'b00); cyc(0, 0, 2'b00);
    chk("post_reset_grow", n_grow, 0);
    chk("post_reset_play", playing_o, 0);

    // randomized play
    st = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) st = ~st;
      ft = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 99);
      c = (r < 80) ? 2'b00 : (r < 93) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        cyc(ft, st, c);
        reset = 1'b1;
      end else begin
        cyc(ft, st, c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
